// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and default geometry for the data-cache line write buffer.
// Optional coalescing of repeated writebacks is enabled with WBUF_COALESCE_EN.
package dcache_write_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } wbuf_state_e;

    localparam int unsigned WBUF_DEPTH  = 4;
    localparam int unsigned WBUF_ADDR_W = 28;
    localparam int unsigned WBUF_LINE_W = 128;
    localparam int unsigned WBUF_PTR_W  = $clog2(WBUF_DEPTH);

endpackage

// File: rtl/dcache_write_buffer_fifo_cam.sv
// Line storage for the write buffer: circular FIFO plus a parallel address
// match that reports the youngest valid entry holding the looked-up line.
module wbuf_fifo_cam
    import dcache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned LINE_W = WBUF_LINE_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              upd,
    input  logic              pop,
    input  logic              excl_head,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic              hit,
    output logic [LINE_W-1:0] hit_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [LINE_W-1:0] head_data,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count_next
);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  hit_idx;
    logic [CNT_W-1:0]  count;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_addr  = addr_q[head];
    assign head_data  = data_q[head];
    assign hit_data   = data_q[hit_idx];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // Walk entries oldest to youngest so the last match wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = head;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i < 32'(count) && !(excl_head && i == 0) &&
                addr_q[head + PTR_W'(i)] == addr) begin
                hit     = 1'b1;
                hit_idx = head + PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= addr;
            data_q[tail] <= wdata;
        end
        if (upd) data_q[hit_idx] <= wdata;
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Line write buffer between the data cache and slow memory; read misses bypass
// queued writebacks. Define WBUF_COALESCE_EN to merge writes to buffered lines.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = WBUF_ADDR_W,
    parameter int unsigned LINE_W = WBUF_LINE_W
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [LINE_W-1:0] c_wdata,
    output logic [LINE_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              wb_empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_e       state, state_next;
    logic              wr_req, rd_req, push, upd, pop, excl_head;
    logic              hit, empty, full, fwd, miss_go, wr_accept;
    logic [LINE_W-1:0] hit_data, head_data;
    logic [ADDR_W-1:0] head_addr;
    logic [CNT_W-1:0]  count_next;

    logic              c_ready_d, mem_read_d, mem_write_d;
    logic [LINE_W-1:0] c_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    // The c_ready cycle is skipped: the cache is still holding the finished request.
    assign wr_req  = c_write && !c_ready;
    assign rd_req  = c_read && !c_write && !c_ready && (state == IDLE || state == WR);
    assign pop     = (state == WR) && mem_ready;
    assign fwd     = rd_req && hit;
    assign miss_go = rd_req && !hit && (state == IDLE);

`ifdef WBUF_COALESCE_EN
    assign excl_head = c_write && (state == WR);
    assign upd       = wr_req && hit;
    assign push      = wr_req && !hit && !full;
`else
    assign excl_head = 1'b0;
    assign upd       = 1'b0;
    assign push      = wr_req && !full;
`endif
    assign wr_accept = push || upd;

    wbuf_fifo_cam #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_fifo_cam (
        .clk        (clk),
        .reset      (proc_reset),
        .push       (push),
        .upd        (upd),
        .pop        (pop),
        .excl_head  (excl_head),
        .addr       (c_addr),
        .wdata      (c_wdata),
        .hit        (hit),
        .hit_data   (hit_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .empty      (empty),
        .full       (full),
        .count_next (count_next)
    );

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            c_ready   <= 1'b0;
            c_rdata   <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_empty  <= 1'b1;
        end else begin
            state     <= state_next;
            c_ready   <= c_ready_d;
            c_rdata   <= c_rdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            wb_empty  <= (count_next == '0) && (state_next != WR);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (miss_go)     state_next = RD;
                else if (!empty) state_next = WR;
            end
            RD:      if (mem_ready) state_next = RESP;
            WR:      if (mem_ready) state_next = IDLE;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        c_ready_d   = wr_accept || fwd;
        c_rdata_d   = fwd ? hit_data : c_rdata;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (miss_go) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = c_addr;
                end else if (!empty) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_data;
                end
            end
            RD: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    c_rdata_d  = mem_rdata;
                    c_ready_d  = 1'b1;
                end
            end
            WR: begin
                if (mem_ready) mem_write_d = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer; the coalescing case follows WBUF_COALESCE_EN.
module tb_dcache_write_buffer;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned LINE_W = 128;

    logic              clk = 1'b0;
    logic              proc_reset = 1'b1;
    logic              c_read = 1'b0;
    logic              c_write = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [LINE_W-1:0] c_wdata = '0;
    logic [LINE_W-1:0] c_rdata;
    logic              c_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              wb_empty;

    int checks = 0;
    int errors = 0;

    logic [LINE_W-1:0] d_a = {4{32'hAAAA_0001}};
    logic [LINE_W-1:0] d_b = {4{32'hBBBB_0002}};
    logic [LINE_W-1:0] d_c = {4{32'hCCCC_0003}};
    logic [LINE_W-1:0] d_d = {4{32'hDDDD_0004}};
    logic [LINE_W-1:0] d_e = {4{32'hEEEE_0005}};

    dcache_write_buffer #(
        .DEPTH  (4),
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .c_read     (c_read),
        .c_write    (c_write),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_rdata    (c_rdata),
        .c_ready    (c_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .wb_empty   (wb_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] data);
        c_write = 1'b1;
        c_addr  = addr;
        c_wdata = data;
        step();
        check_eq({tag, "_ack"}, LINE_W'(c_ready), LINE_W'(1));
        c_write = 1'b0;
        step();
    endtask

    task automatic expect_drain(input string tag, input logic [ADDR_W-1:0] addr,
                                input logic [LINE_W-1:0] data);
        int unsigned n;
        n = 0;
        while (!mem_write && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_req"}, LINE_W'(mem_write), LINE_W'(1));
        check_eq({tag, "_addr"}, LINE_W'(mem_addr), LINE_W'(addr));
        check_eq({tag, "_data"}, mem_wdata, data);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_c_ready"}, LINE_W'(c_ready), '0);
        check_eq({tag, "_mem_read"}, LINE_W'(mem_read), '0);
        check_eq({tag, "_mem_write"}, LINE_W'(mem_write), '0);
        check_eq({tag, "_c_rdata"}, c_rdata, '0);
        check_eq({tag, "_mem_addr"}, LINE_W'(mem_addr), '0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
        check_eq({tag, "_wb_empty"}, LINE_W'(wb_empty), LINE_W'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        proc_reset = 1'b0;
        check_idle_outputs("rst");

        // Single writeback and drain
        c_write = 1'b1; c_addr = 28'h0000100; c_wdata = d_a;
        step();
        check_eq("wb1_ack", LINE_W'(c_ready), LINE_W'(1));
        check_eq("wb1_not_empty", LINE_W'(wb_empty), '0);
        check_eq("wb1_no_mw_yet", LINE_W'(mem_write), '0);
        c_write = 1'b0;
        step();
        check_eq("wb1_ready_drop", LINE_W'(c_ready), '0);
        check_eq("wb1_mw", LINE_W'(mem_write), LINE_W'(1));
        check_eq("wb1_addr", LINE_W'(mem_addr), LINE_W'(28'h0000100));
        check_eq("wb1_data", mem_wdata, d_a);
        step();
        step();
        check_eq("wb1_mw_held", LINE_W'(mem_write), LINE_W'(1));
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("wb1_mw_drop", LINE_W'(mem_write), '0);
        check_eq("wb1_empty", LINE_W'(wb_empty), LINE_W'(1));

        // Fill to DEPTH with memory stalled, then a fifth write
        do_write("f1", 28'h0000101, d_a);
        do_write("f2", 28'h0000102, d_b);
        do_write("f3", 28'h0000103, d_c);
        do_write("f4", 28'h0000104, d_d);
        check_eq("full_head_addr", LINE_W'(mem_addr), LINE_W'(28'h0000101));
        c_write = 1'b1; c_addr = 28'h0000500; c_wdata = d_e;
        step();
        check_eq("full_stall1", LINE_W'(c_ready), '0);
        step();
        check_eq("full_stall2", LINE_W'(c_ready), '0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("full_same_cycle", LINE_W'(c_ready), '0);
        check_eq("full_pop_mw", LINE_W'(mem_write), '0);
        step();
        check_eq("full_accept", LINE_W'(c_ready), LINE_W'(1));
        check_eq("full_next_mw", LINE_W'(mem_write), LINE_W'(1));
        check_eq("full_next_addr", LINE_W'(mem_addr), LINE_W'(28'h0000102));
        c_write = 1'b0;
        expect_drain("fd2", 28'h0000102, d_b);
        expect_drain("fd3", 28'h0000103, d_c);
        expect_drain("fd4", 28'h0000104, d_d);
        expect_drain("fd5", 28'h0000500, d_e);
        check_eq("fill_empty", LINE_W'(wb_empty), LINE_W'(1));

        // Forwarding picks the youngest match
        do_write("fw_a", 28'h0000010, d_a);
        do_write("fw_b", 28'h0000020, d_b);
        do_write("fw_c", 28'h0000010, d_c);
        c_read = 1'b1; c_addr = 28'h0000010;
        step();
        check_eq("fwd_ready", LINE_W'(c_ready), LINE_W'(1));
        check_eq("fwd_data", c_rdata, d_c);
        check_eq("fwd_no_mr", LINE_W'(mem_read), '0);
        c_read = 1'b0;
        step();
        check_eq("fwd_no_mr2", LINE_W'(mem_read), '0);

        // Read miss waits for the in-flight drain, then jumps the queue
        c_read = 1'b1; c_addr = 28'h0000030;
        step();
        check_eq("miss_wait_ready", LINE_W'(c_ready), '0);
        check_eq("miss_wait_mr", LINE_W'(mem_read), '0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("miss_gap_mr", LINE_W'(mem_read), '0);
        check_eq("miss_gap_mw", LINE_W'(mem_write), '0);
        step();
        check_eq("miss_mr", LINE_W'(mem_read), LINE_W'(1));
        check_eq("miss_addr", LINE_W'(mem_addr), LINE_W'(28'h0000030));
        check_eq("miss_no_mw", LINE_W'(mem_write), '0);
        step();
        check_eq("miss_mr_held", LINE_W'(mem_read), LINE_W'(1));
        mem_rdata = d_d; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check_eq("miss_ready", LINE_W'(c_ready), LINE_W'(1));
        check_eq("miss_data", c_rdata, d_d);
        check_eq("miss_mr_drop", LINE_W'(mem_read), '0);
        c_read = 1'b0;
        step();
        check_eq("resp_done", LINE_W'(c_ready), '0);
        check_eq("resp_no_mw", LINE_W'(mem_write), '0);
        expect_drain("md2", 28'h0000020, d_b);
        expect_drain("md3", 28'h0000010, d_c);
        check_eq("miss_empty", LINE_W'(wb_empty), LINE_W'(1));

        // Repeated write to a non-head line
        do_write("co_e", 28'h0000050, d_e);
        do_write("co_a", 28'h0000040, d_a);
        do_write("co_b", 28'h0000040, d_b);
        expect_drain("cd1", 28'h0000050, d_e);
`ifdef WBUF_COALESCE_EN
        expect_drain("cd2", 28'h0000040, d_b);
`else
        expect_drain("cd2", 28'h0000040, d_a);
        expect_drain("cd3", 28'h0000040, d_b);
`endif
        check_eq("co_empty", LINE_W'(wb_empty), LINE_W'(1));

        // Reset while draining with three entries queued
        do_write("r1", 28'h0000060, d_a);
        do_write("r2", 28'h0000061, d_b);
        do_write("r3", 28'h0000062, d_c);
        check_eq("pre_rst_mw", LINE_W'(mem_write), LINE_W'(1));
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0;
        check_idle_outputs("mid_rst");
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("post_rst_mw", LINE_W'(mem_write), '0);
            check_eq("post_rst_empty", LINE_W'(wb_empty), LINE_W'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
